ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. It consumes the decoded operation and operands held in the ID/EX pipeline register and computes the result for the EX/MEM register. The ALU, shift, compare and multiply paths are combinational. DIV/DIVU run on an internal 32-iteration radix-2 divider; while a division is in progress, the block requests a pipeline stall from the stall controller.

## Interface
Parameters: none. Widths come from the global defines: AluOpBus 8 bits, AluSelBus 3 bits, RegBus 32 bits, RegAddrBus 5 bits.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation code (EXE_*_OP)
- alusel_i  in  3  result class (EXE_RES_LOGIC/SHIFT/ARITH/MUL/NOP)
- reg1_i  in  32  operand 1 (rs, or shift amount)
- reg2_i  in  32  operand 2 (rt)
- wd_i  in  5  destination GPR address
- wreg_i  in  1  GPR write enable from decode
- wd_o  out  5  destination GPR address to EX/MEM
- wreg_o  out  1  GPR write enable to EX/MEM
- wdata_o  out  32  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  HI write value
- lo_o  out  32  LO write value
- stallreq_o  out  1  stall request to the stall controller

## Operation
- All outputs are combinational on the inputs and the divider state. While rst=1, all outputs are forced to 0.
- Logic ops: AND, OR, XOR, NOR on reg1_i and reg2_i.
- Shift ops use reg2_i as the value and reg1_i[4:0] as the amount:
  - SLL: logical left.
  - SRL: logical right.
  - SRA: arithmetic right.
- Arithmetic ops:
  - ADD, ADDU: reg1+reg2.
  - SUB, SUBU: reg1-reg2.
  - SLT: signed compare, result 1 or 0.
  - SLTU: unsigned compare, result 1 or 0.
- Signed overflow on ADD or SUB forces wreg_o=0. ADDU and SUBU never suppress the write.
- Multiply ops use a 64-bit product:
  - MULT: signed; hi_o/lo_o = product[63:32]/[31:0], whilo_o=1.
  - MULTU: unsigned; same outputs as MULT.
  - MUL: signed; wdata_o = product[31:0], no HI/LO write.
- wdata_o is selected by alusel_i. EXE_RES_NOP gives 0. wd_o = wd_i and wreg_o = wreg_i unless an overflow suppresses the write.
- Divider FSM states:
  - FREE: on DIV/DIVU with divisor≠0, latch operand magnitudes (|x| for DIV, raw for DIVU), clear counter and go to ON. With divisor=0, go to BYZERO.
  - ON: restoring step, one quotient bit per cycle. After counter reaches 31 (32 ON cycles), go to END. If aluop_i is no longer DIV/DIVU, go to FREE (abort).
  - BYZERO: go to END with quotient=0 and remainder=0.
  - END: drive lo_o = quotient and hi_o = remainder with whilo_o=1. Return to FREE next cycle.
- Sign fix for DIV:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- stallreq_o=1 when:
  - in FREE with aluop_i = DIV or DIVU, or
  - in ON, or
  - in BYZERO.
- stallreq_o=0 in END and for all other ops.
- The stall controller freezes the ID/EX register while stallreq_o=1, so the inputs stay constant for the whole division.

## Timing
- Non-divide ops have zero latency: results are valid in the same cycle the inputs are presented.
- DIV/DIVU with divisor≠0: stallreq_o is high for 33 cycles (the FREE accept cycle plus 32 ON cycles). The result is driven in the 34th cycle (END), with stallreq_o=0. The instruction then advances at that cycle's edge.
- Divide by zero: stallreq_o is high for 2 cycles (FREE, BYZERO). The result is driven in the 3rd cycle.
- After END, FREE is entered and a back-to-back DIV starts a fresh 33-cycle stall.
- rst=1 at any clock edge puts the FSM in FREE with the counter cleared. A division in progress is discarded. It restarts from scratch when the inputs are re-presented after rst=0.
- Only the divider FSM state, its counter, and the dividend/divisor/partial-remainder registers are clocked.

## Test plan
- ADD reg1=0x7FFFFFFF, reg2=1, wreg_i=1 -> wreg_o=0. The same operands with ADDU -> wdata_o=0x80000000, wreg_o=1. SLT reg1=0xFFFFFFFF, reg2=1 -> 1; SLTU with the same operands -> 0.
- SRA reg1=4, reg2=0xF0000000 -> 0xFF000000. SRL with the same operands -> 0x0F000000. SLL reg1=31, reg2=3 -> 0x80000000.
- MULT reg1=0xFFFFFFFF, reg2=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, whilo_o=1. MULTU with the same operands -> hi=1, lo=0xFFFFFFFE. MUL reg1=0x10000, reg2=0x10000 -> wdata_o=0, whilo_o=0.
- DIV reg1=0xFFFFFFF9 (-7), reg2=2, held -> stallreq_o high for exactly 33 cycles. Then one cycle with stallreq_o=0, whilo_o=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU reg1=100, reg2=0 -> 2 stall cycles, then lo=0 and hi=0. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/7: pulse rst on ON cycle 10 -> outputs 0 during reset, FSM in FREE. Re-present after rst=0 -> full 33-cycle stall, then lo=14, hi=2.

Source files
------------

// File: rtl/ex_stage_if.sv
// Execute-stage opcode/width definitions and the ID/EX -> EX/MEM signal bundle.
// The master side is the ID/EX register; the slave side is ex_stage.
package ex_stage_pkg;
  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned ALU_SEL_W  = 3;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALU_OP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_MUL   = 3'b101;
endpackage

interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [ALU_OP_W-1:0]   aluop_i;
  logic [ALU_SEL_W-1:0]  alusel_i;
  logic [REG_W-1:0]      reg1_i;
  logic [REG_W-1:0]      reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [REG_W-1:0]      wdata_o;
  logic                  whilo_o;
  logic [REG_W-1:0]      hi_o;
  logic [REG_W-1:0]      lo_o;
  logic                  stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/shift/compare/multiply plus a
// 32-iteration restoring divider that stalls the pipeline while busy.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  ex
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_e;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_W-1:0]  dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [REG_W-1:0]  dvs_q, dvs_d;
  logic [REG_W-1:0]  rem_q, rem_d;

  logic [REG_W-1:0]  r1, r2;
  logic              is_div, is_sdiv;
  logic [REG_W-1:0]  sum, diff;
  logic              add_ov, sub_ov;
  logic [REG_W-1:0]  logic_res, shift_res, arith_res;
  logic signed [2*REG_W-1:0] r1_sx, r2_sx, prod_s;
  logic [2*REG_W-1:0] prod_u;
  logic [REG_W:0]    shifted, trial;
  logic              step_ok;
  logic [REG_W-1:0]  quot_fix, rem_fix;

  assign r1      = ex.reg1_i;
  assign r2      = ex.reg2_i;
  assign is_sdiv = (ex.aluop_i == EXE_DIV_OP);
  assign is_div  = is_sdiv || (ex.aluop_i == EXE_DIVU_OP);

  assign sum    = r1 + r2;
  assign diff   = r1 - r2;
  assign add_ov = (r1[REG_W-1] == r2[REG_W-1]) && (sum[REG_W-1] != r1[REG_W-1]);
  assign sub_ov = (r1[REG_W-1] != r2[REG_W-1]) && (diff[REG_W-1] != r1[REG_W-1]);

  assign r1_sx  = {{REG_W{r1[REG_W-1]}}, r1};
  assign r2_sx  = {{REG_W{r2[REG_W-1]}}, r2};
  assign prod_s = r1_sx * r2_sx;
  assign prod_u = {{REG_W{1'b0}}, r1} * {{REG_W{1'b0}}, r2};

  always_comb begin
    logic_res = '0;
    case (ex.aluop_i)
      EXE_AND_OP: logic_res = r1 & r2;
      EXE_OR_OP:  logic_res = r1 | r2;
      EXE_XOR_OP: logic_res = r1 ^ r2;
      EXE_NOR_OP: logic_res = ~(r1 | r2);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (ex.aluop_i)
      EXE_SLL_OP: shift_res = r2 << r1[4:0];
      EXE_SRL_OP: shift_res = r2 >> r1[4:0];
      EXE_SRA_OP: shift_res = REG_W'($signed(r2) >>> r1[4:0]);
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (ex.aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP: arith_res = sum;
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = {{(REG_W-1){1'b0}}, ($signed(r1) < $signed(r2))};
      EXE_SLTU_OP: arith_res = {{(REG_W-1){1'b0}}, (r1 < r2)};
      default:     arith_res = '0;
    endcase
  end

  // One restoring step: shift next dividend bit into the partial remainder.
  assign shifted = {rem_q, dvd_q[REG_W-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign step_ok = ~trial[REG_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    case (state_q)
      DIV_FREE: begin
        if (is_div) begin
          if (r2 == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            dvd_d   = (is_sdiv && r1[REG_W-1]) ? (~r1 + 32'd1) : r1;
            dvs_d   = (is_sdiv && r2[REG_W-1]) ? (~r2 + 32'd1) : r2;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV_ON;
          end
        end
      end
      DIV_ON: begin
        if (!is_div) begin
          state_d = DIV_FREE;
        end else begin
          rem_d = step_ok ? trial[REG_W-1:0] : shifted[REG_W-1:0];
          dvd_d = {dvd_q[REG_W-2:0], step_ok};
          cnt_d = CNT_W'(cnt_q + 5'd1);
          if (cnt_q == 5'd31) state_d = DIV_END;
        end
      end
      DIV_BYZERO: begin
        dvd_d   = '0;
        rem_d   = '0;
        state_d = DIV_END;
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
    end
  end

  // Inputs are frozen during a division, so the sign fix reads them directly.
  assign quot_fix = (is_sdiv && (r1[REG_W-1] ^ r2[REG_W-1])) ? (~dvd_q + 32'd1) : dvd_q;
  assign rem_fix  = (is_sdiv && r1[REG_W-1]) ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    ex.wd_o       = '0;
    ex.wreg_o     = 1'b0;
    ex.wdata_o    = '0;
    ex.whilo_o    = 1'b0;
    ex.hi_o       = '0;
    ex.lo_o       = '0;
    ex.stallreq_o = 1'b0;
    if (!rst) begin
      ex.wd_o   = ex.wd_i;
      ex.wreg_o = ex.wreg_i
                  && !((ex.aluop_i == EXE_ADD_OP) && add_ov)
                  && !((ex.aluop_i == EXE_SUB_OP) && sub_ov);
      case (ex.alusel_i)
        EXE_RES_LOGIC: ex.wdata_o = logic_res;
        EXE_RES_SHIFT: ex.wdata_o = shift_res;
        EXE_RES_ARITH: ex.wdata_o = arith_res;
        EXE_RES_MUL:   ex.wdata_o = prod_s[REG_W-1:0];
        default:       ex.wdata_o = '0;
      endcase
      if (ex.aluop_i == EXE_MULT_OP) begin
        ex.whilo_o = 1'b1;
        ex.hi_o    = prod_s[2*REG_W-1:REG_W];
        ex.lo_o    = prod_s[REG_W-1:0];
      end else if (ex.aluop_i == EXE_MULTU_OP) begin
        ex.whilo_o = 1'b1;
        ex.hi_o    = prod_u[2*REG_W-1:REG_W];
        ex.lo_o    = prod_u[REG_W-1:0];
      end else if (state_q == DIV_END) begin
        ex.whilo_o = 1'b1;
        ex.hi_o    = rem_fix;
        ex.lo_o    = quot_fix;
      end
      ex.stallreq_o = ((state_q == DIV_FREE) && is_div)
                      || (state_q == DIV_ON) || (state_q == DIV_BYZERO);
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, divider sequences, and random
// operations compared against an arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .ex(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wreg_in;
    logic [31:0] wdata;
    logic        wreg;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wr);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = wr;
  endtask

  // Reference result of a non-divide op, straight from the arithmetic rules.
  function automatic vec_t model(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b, input logic wr);
    vec_t e;
    longint s;
    longint ps;
    longint unsigned pu;
    logic [31:0] arith, logic_v, shift_v;
    logic ov;
    e = '{op:op, sel:sel, r1:a, r2:b, wreg_in:wr, wdata:0, wreg:wr, whilo:0, hi:0, lo:0};
    ov = 1'b0;
    logic_v = 0; shift_v = 0; arith = 0;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = longint'(a) * longint'(b);
    case (op)
      EXE_AND_OP: logic_v = a & b;
      EXE_OR_OP:  logic_v = a | b;
      EXE_XOR_OP: logic_v = a ^ b;
      EXE_NOR_OP: logic_v = ~(a | b);
      EXE_SLL_OP: shift_v = b << a[4:0];
      EXE_SRL_OP: shift_v = b >> a[4:0];
      EXE_SRA_OP: shift_v = 32'(longint'($signed(b)) / (longint'(1) << a[4:0]) - ((b[31] && (b & ((32'd1 << a[4:0]) - 1)) != 0) ? 1 : 0));
      EXE_ADD_OP, EXE_ADDU_OP: begin
        s = longint'($signed(a)) + longint'($signed(b));
        arith = 32'(s);
        ov = (op == EXE_ADD_OP) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      EXE_SUB_OP, EXE_SUBU_OP: begin
        s = longint'($signed(a)) - longint'($signed(b));
        arith = 32'(s);
        ov = (op == EXE_SUB_OP) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      EXE_SLT_OP:  arith = ($signed(a) < $signed(b)) ? 1 : 0;
      EXE_SLTU_OP: arith = (a < b) ? 1 : 0;
      EXE_MULT_OP:  begin e.whilo = 1; e.hi = 32'(ps >>> 32); e.lo = 32'(ps); end
      EXE_MULTU_OP: begin e.whilo = 1; e.hi = 32'(pu >> 32);  e.lo = 32'(pu); end
      default: ;
    endcase
    case (sel)
      EXE_RES_LOGIC: e.wdata = logic_v;
      EXE_RES_SHIFT: e.wdata = shift_v;
      EXE_RES_ARITH: e.wdata = arith;
      EXE_RES_MUL:   e.wdata = 32'(ps);
      default:       e.wdata = 0;
    endcase
    e.wreg = wr && !ov;
    return e;
  endfunction

  task automatic apply_vec(input string tag, input vec_t v, input logic [4:0] wd);
    @(posedge clk); #1;
    drive(v.op, v.sel, v.r1, v.r2, wd, v.wreg_in);
    @(negedge clk);
    chk({tag, ".wdata"}, 64'(bus.wdata_o), 64'(v.wdata));
    chk({tag, ".wreg"},  64'(bus.wreg_o),  64'(v.wreg));
    chk({tag, ".wd"},    64'(bus.wd_o),    64'(wd));
    chk({tag, ".whilo"}, 64'(bus.whilo_o), 64'(v.whilo));
    chk({tag, ".hilo"},  {bus.hi_o, bus.lo_o}, {v.hi, v.lo});
    chk({tag, ".stall"}, 64'(bus.stallreq_o), 64'd0);
  endtask

  // Caller positions just after a rising edge; counts stall cycles, checks the END cycle.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    drive(op, EXE_RES_NOP, a, b, 5'd0, 1'b0);
    n = 0;
    @(negedge clk);
    while (bus.stallreq_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".stalls"}, 64'(n), 64'(exp_stalls));
    chk({tag, ".stall_end"}, 64'(bus.stallreq_o), 64'd0);
    chk({tag, ".whilo"}, 64'(bus.whilo_o), 64'd1);
    chk({tag, ".lo"}, 64'(bus.lo_o), 64'(exp_lo));
    chk({tag, ".hi"}, 64'(bus.hi_o), 64'(exp_hi));
  endtask

  function automatic void div_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 0; r = 0;
    end else if (op == EXE_DIVU_OP) begin
      q = a / b; r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  vec_t vecs[$];
  logic [7:0] rops[15];
  logic [2:0] rsels[15];

  initial begin
    drive(EXE_ADD_OP, EXE_RES_ARITH, 32'd1, 32'd2, 5'd5, 1'b1);
    @(negedge clk);
    chk("rst.wdata", 64'(bus.wdata_o), 64'd0);
    chk("rst.wreg",  64'(bus.wreg_o), 64'd0);
    chk("rst.wd",    64'(bus.wd_o), 64'd0);
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd9, 32'd3, 5'd5, 1'b0);
    @(negedge clk);
    chk("rst.stall", 64'(bus.stallreq_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, 0, 0, 0, 0);

    vecs.push_back('{EXE_ADD_OP,  EXE_RES_ARITH, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 0, 0, 0, 0});
    vecs.push_back('{EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFFFFFF, 32'h1, 1, 32'h80000000, 1, 0, 0, 0});
    vecs.push_back('{EXE_SLT_OP,  EXE_RES_ARITH, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 1, 0, 0, 0});
    vecs.push_back('{EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1, 0, 0, 0});
    vecs.push_back('{EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4, 32'hF0000000, 1, 32'hFF000000, 1, 0, 0, 0});
    vecs.push_back('{EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4, 32'hF0000000, 1, 32'h0F000000, 1, 0, 0, 0});
    vecs.push_back('{EXE_SLL_OP,  EXE_RES_SHIFT, 32'd31, 32'd3, 1, 32'h80000000, 1, 0, 0, 0});
    vecs.push_back('{EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 1, 32'h1, 32'hFFFFFFFE});
    vecs.push_back('{EXE_MUL_OP,  EXE_RES_MUL, 32'h10000, 32'h10000, 1, 32'h0, 1, 0, 0, 0});
    vecs.push_back('{EXE_SUB_OP,  EXE_RES_ARITH, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 0, 0, 0, 0});
    vecs.push_back('{EXE_SUBU_OP, EXE_RES_ARITH, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 1, 0, 0, 0});
    vecs.push_back('{EXE_NOR_OP,  EXE_RES_LOGIC, 32'hF0F0F0F0, 32'h0000FFFF, 1, 32'h0F0F0000, 1, 0, 0, 0});
    vecs.push_back('{EXE_XOR_OP,  EXE_RES_LOGIC, 32'hF0F0F0F0, 32'h0000FFFF, 1, 32'hF0F00F0F, 1, 0, 0, 0});
    vecs.push_back('{EXE_ADD_OP,  EXE_RES_NOP, 32'd5, 32'd6, 1, 32'h0, 1, 0, 0, 0});
    foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i], 5'(i + 3));

    @(posedge clk); #1; run_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    @(posedge clk); #1; run_div("div_b2b", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    @(posedge clk); #1; run_div("divu_zero", EXE_DIVU_OP, 32'd100, 32'd0, 2, 32'd0, 32'd0);
    @(posedge clk); #1; run_div("div_min", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);

    // Reset in the middle of a division discards it; held inputs then restart it.
    @(posedge clk); #1;
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("rstdiv.stall", 64'(bus.stallreq_o), 64'd0);
    chk("rstdiv.whilo", 64'(bus.whilo_o), 64'd0);
    chk("rstdiv.hilo",  {bus.hi_o, bus.lo_o}, 64'd0);
    chk("rstdiv.wd",    64'(bus.wd_o), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    run_div("divu_after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    rops  = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
              EXE_SLT_OP, EXE_SLTU_OP, EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP,
              EXE_MULT_OP, EXE_MUL_OP};
    rsels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
              EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
              EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_NOP, EXE_RES_MUL};
    for (int i = 0; i < 200; i++) begin
      int k;
      logic [31:0] a, b;
      logic wr;
      k  = $urandom_range(0, 14);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'(a ^ 32'h80000000) : 32'($urandom);
      wr = 1'($urandom_range(0, 1));
      if (i % 20 == 0) begin
        apply_vec($sformatf("rnd%0d", i), model(EXE_MULTU_OP, EXE_RES_NOP, a, b, wr), 5'(i));
      end else begin
        apply_vec($sformatf("rnd%0d", i), model(rops[k], rsels[k], a, b, wr), 5'(i));
      end
    end

    for (int i = 0; i < 16; i++) begin
      logic [7:0] op;
      logic [31:0] a, b, q, r;
      op = (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a  = $urandom;
      case (i % 4)
        0: b = 32'($urandom_range(1, 50));
        1: b = 32'(0 - $urandom_range(1, 50));
        2: b = $urandom;
        default: b = (i == 7) ? 32'd0 : 32'($urandom_range(1, 1000));
      endcase
      div_model(op, a, b, q, r);
      @(posedge clk); #1;
      run_div($sformatf("rdiv%0d", i), op, a, b, (b == 0) ? 2 : 33, q, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
